// File: rtl/light_timer_pkg.sv
// Shared encodings and default tick constants for the light-controller interval timer.
package light_timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    localparam int DEF_TSE_TICKS   = 2;
    localparam int DEF_SHORT_TICKS = 5;
    localparam int DEF_LONG_TICKS  = 20;
    localparam int DEF_PRESCALE    = 4;

    function automatic logic reached(input int unsigned ticks, input int unsigned thr);
        return ticks >= thr;
    endfunction

endpackage

// File: rtl/light_timer_tick_gen.sv
// Down-counting prescaler: tick pulses once every PRESCALE clocks; clr restarts the phase.
module tick_gen #(
    parameter int PRESCALE = 4
) (
    input  logic Clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    always_comb begin
        tick    = (phase_q == '0);
        phase_d = phase_q - PW'(1);
        // clr reloads so the first tick lands PRESCALE clocks after it
        if (clr || tick) begin
            phase_d = PW'(PRESCALE - 1);
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/light_timer.sv
// Dwell-time timer for the light controller: ST restarts, TSE/TS/TL flag elapsed ticks.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN.
module light_timer
    import light_timer_pkg::*;
#(
    parameter int TSE_TICKS   = DEF_TSE_TICKS,
    parameter int SHORT_TICKS = DEF_SHORT_TICKS,
    parameter int LONG_TICKS  = DEF_LONG_TICKS,
    parameter int PRESCALE    = DEF_PRESCALE
) (
    input  logic Clk,
    input  logic reset,
    input  logic ST,
    output logic TSE,
    output logic TS,
    output logic TL,
    output logic Busy
);
    localparam int CNT_W = $clog2(LONG_TICKS + 1);

    if (TSE_TICKS < 1 || TSE_TICKS >= SHORT_TICKS || SHORT_TICKS >= LONG_TICKS
        || PRESCALE < 2) begin : g_param_check
        $error("light_timer: illegal tick parameters");
    end

    logic tick;

`ifdef TIMER_PRESCALE_EN
    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .Clk  (Clk),
        .reset(reset),
        .clr  (ST),
        .tick (tick)
    );
`else
    assign tick = 1'b1;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             tse_q, tse_d;
    logic             ts_q, ts_d;
    logic             tl_q, tl_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tse_d   = tse_q;
        ts_d    = ts_q;
        tl_d    = tl_q;
        cnt_inc = count_q + CNT_W'(1);
        if (ST) begin
            state_d = S_RUN;
            count_d = '0;
            tse_d   = 1'b0;
            ts_d    = 1'b0;
            tl_d    = 1'b0;
        end else if (state_q == S_RUN && tick) begin
            // Only RUN advances, so count saturates at LONG_TICKS via EXPIRED
            count_d = cnt_inc;
            tse_d   = reached(32'(cnt_inc), TSE_TICKS);
            ts_d    = reached(32'(cnt_inc), SHORT_TICKS);
            tl_d    = reached(32'(cnt_inc), LONG_TICKS);
            if (cnt_inc >= CNT_W'(LONG_TICKS)) begin
                state_d = S_EXPIRED;
            end
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            tse_q   <= 1'b0;
            ts_q    <= 1'b0;
            tl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tse_q   <= tse_d;
            ts_q    <= ts_d;
            tl_q    <= tl_d;
        end
    end

    assign TSE  = tse_q;
    assign TS   = ts_q;
    assign TL   = tl_q;
    assign Busy = (state_q == S_RUN);

endmodule

// File: tb/tb_light_timer.sv
// Scoreboard bench for light_timer: directed scenarios plus random ST/reset traffic.
module tb_light_timer;

    localparam int TSE_N   = 2;
    localparam int SHORT_N = 5;
    localparam int LONG_N  = 20;
`ifdef TIMER_PRESCALE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st  = 1'b0;
    logic tse, ts, tl, busy;

    light_timer #(
        .TSE_TICKS  (TSE_N),
        .SHORT_TICKS(SHORT_N),
        .LONG_TICKS (LONG_N),
        .PRESCALE   (4)
    ) dut (
        .Clk  (clk),
        .reset(rst),
        .ST   (st),
        .TSE  (tse),
        .TS   (ts),
        .TL   (tl),
        .Busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int txn;
        bit st_v;
        bit [3:0] flags;   // {TSE, TS, TL, Busy}
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference: elapsed ticks since the last ST edge, by plain arithmetic
    int edge_cnt = 0;
    int last_st  = 0;
    bit started  = 0;
    int txn_id   = 0;

    task automatic model_step();
        exp_t e;
        int   ticks;
        edge_cnt++;
        if (rst) begin
            started = 0;
        end else if (st) begin
            started = 1;
            last_st = edge_cnt;
        end
        ticks = (edge_cnt - last_st) / P;
        e.txn   = txn_id++;
        e.st_v  = st;
        e.flags = {started && ticks >= TSE_N, started && ticks >= SHORT_N,
                   started && ticks >= LONG_N, started && ticks < LONG_N};
        sb.push_back(e);
    endtask

    task automatic cycle(input bit st_v);
        @(negedge clk);
        st = st_v;
        @(posedge clk);
        model_step();
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if ({tse, ts, tl, busy} != 4'b0000) begin
            n_fail++;
            $display("FAIL %s: got TSE/TS/TL/Busy=%b required 0000", name, {tse, ts, tl, busy});
        end else begin
            $display("%s: outputs 0000 ok", name);
        end
    endtask

    task automatic async_rst(input int hold);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_idle("async_reset");
        started = 0;
        repeat (hold) cycle(1'b0);
        @(negedge clk);
        rst = 1'b0;
        st  = 1'b0;
    endtask

    // Monitor: the DUT presents its flags every cycle; compare just after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({tse, ts, tl, busy} !== e.flags) begin
                    n_fail++;
                    $display("FAIL txn %0d flags: got TSE/TS/TL/Busy=%b required %b (st=%0b)",
                             e.txn, {tse, ts, tl, busy}, e.flags, e.st_v);
                end else begin
                    $display("txn %0d st=%0b TSE/TS/TL/Busy=%b ok", e.txn, e.st_v, e.flags);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 check_idle("reset_state");
        repeat (3) cycle(1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Idle before any ST
        repeat (5) cycle(1'b0);
        // Single pulse through expiry
        cycle(1'b1);
        repeat (25 * P) cycle(1'b0);
        // Re-pulse mid-measurement
        cycle(1'b1);
        repeat (9 * P) cycle(1'b0);
        cycle(1'b1);
        repeat (25 * P) cycle(1'b0);
        // ST held for three edges
        repeat (3) cycle(1'b1);
        repeat (25 * P) cycle(1'b0);
        // Async reset at count 7, then quiet
        cycle(1'b1);
        repeat (7 * P) cycle(1'b0);
        async_rst(1);
        repeat (50) cycle(1'b0);
        // Saturation after TL
        cycle(1'b1);
        repeat (20 * P + 100) cycle(1'b0);
        // Restart off a prescaler phase boundary
        cycle(1'b1);
        repeat (12) cycle(1'b0);
        cycle(1'b1);
        repeat (25 * P) cycle(1'b0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_rst($urandom_range(0, 3));
            end else begin
                cycle($urandom_range(0, 11) == 0);
            end
        end

        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
